// File: rtl/packet_fifo_f2h_mm.sv
`timescale 1ns/1ps
// Packet FIFO from an FPGA stream to a host memory-mapped port, atomic commit on EOP.
// Optional interrupt output and CONTROL irq_en bit are built with `define PKTFIFO_IRQ_EN.
module packet_fifo_f2h_mm #(
    parameter int DEPTH_LOG2 = 9,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic [3:0]        byte_enable,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       write_data,
    output logic              acknowledge,
    output logic [31:0]       read_data
`ifdef PKTFIFO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP} state_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    logic [32:0] mem_q [DEPTH];

    state_t      state_q, state_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        commit_ptr_q, commit_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        uf_q, uf_d;
    logic        ovf_q, ovf_d;
    logic        frame_q, frame_d;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic                  commit_inc;
    logic                  frame_set;
    logic                  ovf_set;
    ptr_t                  base_ptr;
    logic                  blocked;

    logic        host_acc, host_wr, host_rd;
    logic        addr_hit;
    logic [1:0]  a_sel;
    logic        pop, pop_eop, uf_set, flush, clr;
    logic [31:0] status, ctrl_rd;

    ptr_t        level, used;
    logic        full, restart_full;
    logic [32:0] head;

    logic        unused_bits;

    assign level        = commit_ptr_q - rd_ptr_q;
    assign used         = wr_ptr_q - rd_ptr_q;
    assign full         = (used == DEPTH_P);
    assign restart_full = (level == DEPTH_P);
    assign head         = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    assign host_acc = (read | write) & ~ack_q;
    assign host_wr  = host_acc & write;
    assign host_rd  = host_acc & read & ~write;
    assign addr_hit = ((address >> 2) == '0);
    assign a_sel    = address[1:0];

    assign status = {10'b0, frame_q, ovf_q, uf_q,
                     (level != '0) & head[32],
                     full, (level == '0), 16'(level)};

    assign unused_bits = ^{byte_enable, write_data[31:2]};

`ifdef PKTFIFO_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;
    assign ctrl_rd = {29'b0, irq_en_q, 2'b0};
    assign irq     = irq_q;
`else
    assign ctrl_rd = '0;
`endif

    always_comb begin
        rdata_d = '0;
        pop     = 1'b0;
        uf_set  = 1'b0;
        flush   = 1'b0;
        clr     = 1'b0;
`ifdef PKTFIFO_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (host_wr && addr_hit && a_sel == 2'd3) begin
            flush = write_data[0];
            clr   = write_data[1];
`ifdef PKTFIFO_IRQ_EN
            irq_en_d = write_data[2];
`endif
        end
        if (host_rd && addr_hit) begin
            unique case (a_sel)
                2'd0: begin
                    if (level != '0) begin
                        pop     = 1'b1;
                        rdata_d = head[31:0];
                    end else begin
                        uf_set = 1'b1;
                    end
                end
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {16'h0, pkt_count_q};
                default: rdata_d = ctrl_rd;
            endcase
        end
    end

    assign pop_eop = pop & head[32];

    // A sop inside a packet restarts at the last commit point.
    assign base_ptr = (state_q == S_PKT && in_sop) ? commit_ptr_q : wr_ptr_q;
    assign blocked  = (state_q == S_PKT && in_sop) ? restart_full : full;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + ptr_t'(pop);
        mem_we       = 1'b0;
        mem_waddr    = base_ptr[DEPTH_LOG2-1:0];
        commit_inc   = 1'b0;
        frame_set    = 1'b0;
        ovf_set      = 1'b0;
        if (in_valid && !flush) begin
            unique case (state_q)
                S_IDLE, S_PKT: begin
                    if (state_q == S_IDLE && !in_sop) begin
                        frame_set = 1'b1;
                    end else begin
                        frame_set = (state_q == S_PKT) & in_sop;
                        if (blocked) begin
                            wr_ptr_d = commit_ptr_q;
                            ovf_set  = 1'b1;
                            state_d  = in_eop ? S_IDLE : S_DROP;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = base_ptr + ptr_t'(1);
                            if (in_eop) begin
                                commit_ptr_d = base_ptr + ptr_t'(1);
                                commit_inc   = 1'b1;
                                state_d      = S_IDLE;
                            end else begin
                                state_d = S_PKT;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (in_eop) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (flush) begin
            state_d      = S_IDLE;
            wr_ptr_d     = '0;
            commit_ptr_d = '0;
            rd_ptr_d     = '0;
        end
    end

    always_comb begin
        if (flush) begin
            pkt_count_d = '0;
        end else begin
            pkt_count_d = pkt_count_q + 16'(commit_inc) - 16'(pop_eop);
        end
        uf_d    = (uf_q & ~clr) | uf_set;
        ovf_d   = (ovf_q & ~clr) | ovf_set;
        frame_d = (frame_q & ~clr) | frame_set;
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= {in_eop, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            uf_q         <= 1'b0;
            ovf_q        <= 1'b0;
            frame_q      <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            uf_q         <= uf_d;
            ovf_q        <= ovf_d;
            frame_q      <= frame_d;
            ack_q        <= host_acc;
            rdata_q      <= rdata_d;
        end
    end

`ifdef PKTFIFO_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & ((pkt_count_d != 16'h0) | ovf_d);
        end
    end
`endif

    assign in_ready    = ~reset;
    assign acknowledge = ack_q;
    assign read_data   = rdata_q;

endmodule

// File: tb/tb_packet_fifo_f2h_mm.sv
`timescale 1ns/1ps
// Self-checking bench for packet_fifo_f2h_mm against a queue-based packet model.
module tb_packet_fifo_f2h_mm;

    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_sop, in_eop, in_valid;
    logic        in_ready;
    logic [2:0]  address;
    logic [3:0]  byte_enable;
    logic        read, write;
    logic [31:0] write_data;
    logic        acknowledge;
    logic [31:0] read_data;
`ifdef PKTFIFO_IRQ_EN
    logic        irq;
`endif

    packet_fifo_f2h_mm #(.DEPTH_LOG2(DL), .ADDR_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_sop(in_sop),
        .in_eop(in_eop),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .address(address),
        .byte_enable(byte_enable),
        .read(read),
        .write(write),
        .write_data(write_data),
        .acknowledge(acknowledge),
        .read_data(read_data)
`ifdef PKTFIFO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [32:0] cq[$];
    logic [32:0] pq[$];
    int          m_st;
    bit          m_uf, m_ovf, m_fe, m_irqen, m_irq;
    bit          prev_req;
    logic [31:0] last;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pkts();
        int n = 0;
        foreach (cq[i]) if (cq[i][32]) n++;
        return n;
    endfunction

    task automatic model_reset();
        cq.delete();
        pq.delete();
        m_st = 0;
        m_uf = 0; m_ovf = 0; m_fe = 0; m_irqen = 0; m_irq = 0;
        prev_req = 0;
    endtask

    task automatic model(input logic v, sop, eop, input logic [31:0] d,
                         input logic hr, hw, input logic [2:0] a,
                         input logic [31:0] wd, output logic [31:0] e);
        int          csz;
        bit          full, cfull, flush, clr, ufs, ovs, fes;
        logic [32:0] w, t;
        csz   = cq.size();
        full  = (cq.size() + pq.size()) == DEPTH;
        cfull = (csz == DEPTH);
        flush = 0; clr = 0; ufs = 0; ovs = 0; fes = 0;
        w = {eop, d};
        e = '0;
        if (hw && a == 3'd3) begin
            flush = wd[0];
            clr   = wd[1];
`ifdef PKTFIFO_IRQ_EN
            m_irqen = wd[2];
`endif
        end
        if (hr && !hw) begin
            case (a)
                3'd0: begin
                    if (csz > 0) begin
                        t = cq.pop_front();
                        e = t[31:0];
                    end else begin
                        ufs = 1;
                    end
                end
                3'd1: e = {10'b0, m_fe, m_ovf, m_uf,
                           (csz > 0) ? cq[0][32] : 1'b0,
                           full, csz == 0, 16'(csz)};
                3'd2: e = 32'(pkts());
                3'd3: e = {29'b0, m_irqen, 2'b0};
                default: e = '0;
            endcase
        end
        if (v && !flush) begin
            case (m_st)
                0: begin
                    if (!sop) fes = 1;
                    else if (full) begin
                        ovs = 1;
                        if (!eop) m_st = 2;
                    end else if (eop) cq.push_back(w);
                    else begin
                        pq.push_back(w);
                        m_st = 1;
                    end
                end
                1: begin
                    if (sop) begin
                        fes = 1;
                        pq.delete();
                        if (cfull) begin
                            ovs = 1;
                            m_st = eop ? 0 : 2;
                        end else if (eop) begin
                            cq.push_back(w);
                            m_st = 0;
                        end else pq.push_back(w);
                    end else if (full) begin
                        pq.delete();
                        ovs = 1;
                        m_st = eop ? 0 : 2;
                    end else begin
                        pq.push_back(w);
                        if (eop) begin
                            foreach (pq[i]) cq.push_back(pq[i]);
                            pq.delete();
                            m_st = 0;
                        end
                    end
                end
                default: if (eop) m_st = 0;
            endcase
        end
        if (flush) begin
            cq.delete();
            pq.delete();
            m_st = 0;
        end
        m_uf  = (m_uf && !clr) || ufs;
        m_ovf = (m_ovf && !clr) || ovs;
        m_fe  = (m_fe && !clr) || fes;
        m_irq = m_irqen && (pkts() != 0 || m_ovf);
    endtask

    task automatic step(input logic v, sop, eop, input logic [31:0] d,
                        input logic hr, hw, input logic [2:0] a,
                        input logic [31:0] wd);
        logic [31:0] e;
        in_valid = v; in_sop = sop; in_eop = eop; in_data = d;
        read = hr; write = hw; address = a; write_data = wd;
        byte_enable = 4'($urandom);
        @(posedge clk);
        model(v, sop, eop, d, hr, hw, a, wd, e);
        #1;
        in_valid = 0; read = 0; write = 0;
        prev_req = hr | hw;
        chk("in_ready", {31'b0, in_ready}, 32'd1);
        chk("ack", {31'b0, acknowledge}, {31'b0, hr | hw});
        if (hr && !hw) begin
            last = read_data;
            chk($sformatf("rd_a%0d", a), read_data, e);
        end
`ifdef PKTFIFO_IRQ_EN
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    endtask

    task automatic cyc(input logic v, sop, eop, input logic [31:0] d,
                       input logic hr, hw, input logic [2:0] a,
                       input logic [31:0] wd);
        if ((hr | hw) && prev_req) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(v, sop, eop, d, hr, hw, a, wd);
    endtask

    task automatic sw(input logic sop, eop, input logic [31:0] d);
        cyc(1, sop, eop, d, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(0, 0, 0, 0, 1, 0, a, 0);
    endtask

    task automatic wrc(input logic [31:0] wd);
        cyc(0, 0, 0, 0, 0, 1, 3'd3, wd);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_ack", {31'b0, acknowledge}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
`ifdef PKTFIFO_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 32'd0);
`endif
        reset = 0;
        model_reset();
    endtask

    initial begin
        reset = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_data = 0;
        read = 0; write = 0; address = 0; write_data = 0; byte_enable = 0;
        last = 0;
        model_reset();
        do_reset();
        rd(1);
        chk("rst_status", last, 32'h0001_0000);

        sw(1, 0, 32'h11); sw(0, 0, 32'h12); sw(0, 0, 32'h13); sw(0, 1, 32'h14);
        rd(2); chk("A_pktcnt", last, 32'd1);
        rd(1); chk("A_level", {16'h0, last[15:0]}, 32'd4);
        rd(0); chk("A_d0", last, 32'h11);
        rd(0); chk("A_d1", last, 32'h12);
        rd(0); chk("A_d2", last, 32'h13);
        rd(1); chk("A_headeop", {31'b0, last[18]}, 32'd1);
        rd(0); chk("A_d3", last, 32'h14);
        rd(2); chk("A_pktcnt0", last, 32'd0);

        sw(1, 0, 32'h21); sw(0, 0, 32'h22); sw(0, 0, 32'h23);
        rd(1); chk("B_level0", {16'h0, last[15:0]}, 32'd0);
        rd(2); chk("B_pktcnt0", last, 32'd0);
        rd(0); chk("B_under_data", last, 32'd0);
        rd(1); chk("B_underflow", {31'b0, last[19]}, 32'd1);
        sw(0, 1, 32'h24);
        rd(1); chk("B_level4", {16'h0, last[15:0]}, 32'd4);
        wrc(32'h2);
        repeat (4) rd(0);

        sw(1, 0, 32'h31); sw(0, 0, 32'h32); sw(0, 1, 32'h33);
        sw(1, 0, 32'h41); sw(0, 0, 32'h42); sw(0, 1, 32'h43);
        rd(1);
        chk("C_level3", {16'h0, last[15:0]}, 32'd3);
        chk("C_ovf", {31'b0, last[20]}, 32'd1);
        sw(1, 1, 32'h51);
        rd(1);
        chk("C_level4", {16'h0, last[15:0]}, 32'd4);
        chk("C_full", {31'b0, last[17]}, 32'd1);

        rd(0); rd(0); rd(0);
        sw(1, 0, 32'h61);
        cyc(1, 0, 1, 32'h62, 1, 0, 3'd0, 0);
        chk("D_popdata", last, 32'h51);
        rd(2); chk("D_pktcnt", last, 32'd1);
        rd(1); chk("D_level", {16'h0, last[15:0]}, 32'd2);
        rd(0); rd(0);

        sw(1, 0, 32'h71);
        cyc(1, 0, 0, 32'h72, 0, 1, 3'd3, 32'h1);
        rd(1); chk("E_level0", {16'h0, last[15:0]}, 32'd0);
        rd(2); chk("E_pktcnt0", last, 32'd0);
        sw(1, 0, 32'h81); sw(0, 1, 32'h82);
        rd(1); chk("E_level2", {16'h0, last[15:0]}, 32'd2);
        rd(0); chk("E_d0", last, 32'h81);
        rd(0); chk("E_d1", last, 32'h82);

        wrc(32'h6);
        sw(1, 1, 32'h91);
`ifdef PKTFIFO_IRQ_EN
        chk("F_irq_on", {31'b0, irq}, 32'd1);
`endif
        rd(0);
`ifdef PKTFIFO_IRQ_EN
        chk("F_irq_off", {31'b0, irq}, 32'd0);
`endif
        rd(3);
`ifdef PKTFIFO_IRQ_EN
        chk("F_ctrl", last, 32'h4);
`else
        chk("F_ctrl", last, 32'h0);
`endif
        wrc(32'h0);

        sw(1, 1, 32'hA1);
        sw(1, 0, 32'hA2);
        if (prev_req) step(0, 0, 0, 0, 0, 0, 0, 0);
        read = 1; address = 3'd0; reset = 1;
        @(posedge clk);
        #1;
        chk("G_noack", {31'b0, acknowledge}, 32'd0);
        read = 0;
        do_reset();
        rd(1); chk("G_status", last, 32'h0001_0000);

        for (int i = 0; i < 800; i++) begin
            logic        v, s, e, hr, hw;
            logic [2:0]  a;
            logic [31:0] wd;
            int          r;
            v  = ($urandom_range(0, 9) < 6);
            s  = ($urandom_range(0, 9) < 3);
            e  = ($urandom_range(0, 9) < 3);
            hr = 0; hw = 0; a = 0; wd = 0;
            r  = $urandom_range(0, 99);
            if (r < 30) begin
                hr = 1;
            end else if (r < 42) begin
                hr = 1;
                a = 3'($urandom_range(1, 7));
            end else if (r < 47) begin
                hw = 1;
                a = 3'($urandom_range(0, 7));
                wd = $urandom;
                wd[0] = ($urandom_range(0, 3) == 0);
            end else if (r < 49) begin
                hr = 1; hw = 1;
                a = 3'($urandom_range(0, 3));
                wd = 32'($urandom_range(0, 7)) & 32'h6;
            end
            cyc(v, s, e, $urandom, hr, hw, a, wd);
        end
        for (int i = 0; i < 3; i++) rd(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
